// File: rtl/cpu_control_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_defs_pkg
//  Description : Shared definitions for the CPU control unit: field widths,
//                opcodes, FSM state encodings, opcode classes, the strobe
//                bundle and a helper giving the last execute state per class.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_defs_pkg;

    localparam int CPU_OPW = 5;   // opcode field width, IR[31:27]
    localparam int CPU_DW  = 32;  // instruction register width

    // Opcodes
    localparam logic [CPU_OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [CPU_OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [CPU_OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [CPU_OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [CPU_OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [CPU_OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [CPU_OPW-1:0] OP_ROR  = 5'b00111;
    localparam logic [CPU_OPW-1:0] OP_ROL  = 5'b01000;
    localparam logic [CPU_OPW-1:0] OP_SHR  = 5'b01001;
    localparam logic [CPU_OPW-1:0] OP_SHRA = 5'b01010;
    localparam logic [CPU_OPW-1:0] OP_SHL  = 5'b01011;
    localparam logic [CPU_OPW-1:0] OP_ADDI = 5'b01100;
    localparam logic [CPU_OPW-1:0] OP_ANDI = 5'b01101;
    localparam logic [CPU_OPW-1:0] OP_ORI  = 5'b01110;
    localparam logic [CPU_OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [CPU_OPW-1:0] OP_MUL  = 5'b10000;
    localparam logic [CPU_OPW-1:0] OP_NEG  = 5'b10001;
    localparam logic [CPU_OPW-1:0] OP_NOT  = 5'b10010;
    localparam logic [CPU_OPW-1:0] OP_NOP  = 5'b11010;
    localparam logic [CPU_OPW-1:0] OP_HALT = 5'b11011;

    // FSM states; T0..T7 are consecutive so execute steps advance by +1
    typedef enum logic [3:0] {
        ST_RST  = 4'd0,
        ST_T0   = 4'd1,
        ST_T1   = 4'd2,
        ST_T2   = 4'd3,
        ST_T3   = 4'd4,
        ST_T4   = 4'd5,
        ST_T5   = 4'd6,
        ST_T6   = 4'd7,
        ST_T7   = 4'd8,
        ST_HALT = 4'd9
    } state_t;

    // Opcode classes
    typedef enum logic [2:0] {
        CLS_NOP    = 3'd0,
        CLS_ALU3   = 3'd1,
        CLS_IMM    = 3'd2,
        CLS_UNARY  = 3'd3,
        CLS_MULDIV = 3'd4,
        CLS_LD     = 3'd5,
        CLS_ST     = 3'd6,
        CLS_HALT   = 3'd7
    } opclass_t;

    // Datapath strobe bundle (alu_op and run are carried separately)
    typedef struct packed {
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic c_out;
        logic ba_out;
        logic mar_in;
        logic z_in;
        logic pc_in;
        logic mdr_in;
        logic ir_in;
        logic y_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic read;
        logic write;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
    } ctrl_t;

    // Last state of an instruction (its boundary). NOP/undefined end at T2.
    function automatic state_t last_state(input opclass_t cls);
        case (cls)
            CLS_UNARY:           last_state = ST_T4;
            CLS_ALU3, CLS_IMM:   last_state = ST_T5;
            CLS_MULDIV:          last_state = ST_T6;
            CLS_LD, CLS_ST:      last_state = ST_T7;
            default:             last_state = ST_T2;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_control_unit_if.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_if
//  Description : Control bus between the control unit (master) and the
//                datapath (slave).
//                master: in  stop, ir        out strobes, alu_op, run
//                slave : out stop, ir        in  strobes, alu_op, run
//  Revision    : 1.0 - initial release
// ============================================================================
interface cpu_ctrl_if #(
    parameter int OPW = cpu_defs_pkg::CPU_OPW,
    parameter int DW  = cpu_defs_pkg::CPU_DW
);
    logic           stop;
    logic [DW-1:0]  ir;

    logic pc_out, zhigh_out, zlow_out, mdr_out, c_out, ba_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in;
    logic inc_pc, read, write;
    logic gra, grb, grc, r_in, r_out;
    logic [OPW-1:0] alu_op;
    logic           run;

    modport master (
        input  stop, ir,
        output pc_out, zhigh_out, zlow_out, mdr_out, c_out, ba_out,
        output mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in,
        output inc_pc, read, write,
        output gra, grb, grc, r_in, r_out,
        output alu_op, run
    );

    modport slave (
        output stop, ir,
        input  pc_out, zhigh_out, zlow_out, mdr_out, c_out, ba_out,
        input  mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in,
        input  inc_pc, read, write,
        input  gra, grb, grc, r_in, r_out,
        input  alu_op, run
    );
endinterface
`default_nettype wire

// File: rtl/cpu_control_unit_opclass_decode.sv
`default_nettype none
// ============================================================================
//  Module      : opclass_decode
//  Description : Combinational opcode -> opcode-class decoder. Undefined
//                opcodes fall into the NOP class.
//                in  op      : opcode field IR[31:27]
//                out opclass : decoded class
//  Revision    : 1.0 - initial release
// ============================================================================
module opclass_decode
    import cpu_defs_pkg::*;
(
    input  logic [CPU_OPW-1:0] op,
    output opclass_t           opclass
);

    always_comb begin
        opclass = CLS_NOP;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
            OP_ROL, OP_SHR, OP_SHRA, OP_SHL:   opclass = CLS_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:          opclass = CLS_IMM;
            OP_NEG, OP_NOT:                    opclass = CLS_UNARY;
            OP_DIV, OP_MUL:                    opclass = CLS_MULDIV;
            OP_LD:                             opclass = CLS_LD;
            OP_ST:                             opclass = CLS_ST;
            OP_HALT:                           opclass = CLS_HALT;
            default:                           opclass = CLS_NOP;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/cpu_control_unit.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_control_unit
//  Description : Moore FSM sequencing the bus-based datapath through fetch
//                (T0-T2) and class-dependent execute (T3-T7). Strobes are a
//                function of the state register and IR only.
//                in  clk  : system clock, rising edge
//                in  rst  : asynchronous active-high reset (state -> RST)
//                bus      : cpu_ctrl_if.master (stop, ir in; strobes out)
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_control_unit
    import cpu_defs_pkg::*;
#(
    parameter int OPW = CPU_OPW,
    parameter int DW  = CPU_DW
) (
    input  logic            clk,
    input  logic            rst,
    cpu_ctrl_if.master      bus
);

    state_t          r_state;
    logic            r_stop_req;   // stop seen earlier in the current instruction

    logic [OPW-1:0]  w_op;
    opclass_t        w_cls;
    logic            w_running;
    logic            w_boundary;
    logic            w_stop_pending;
    ctrl_t           w_ctrl;
    logic [OPW-1:0]  w_alu_op;
    logic            w_unused_ir;

    assign w_op        = bus.ir[DW-1 -: OPW];
    assign w_unused_ir = ^bus.ir[DW-OPW-1:0];

    opclass_decode u_opclass_decode (
        .op      (w_op),
        .opclass (w_cls)
    );

    assign w_running      = (r_state >= ST_T0) && (r_state <= ST_T7);
    assign w_boundary     = w_running && (r_state == last_state(w_cls));
    // Stop is a request: one held any time during the instruction counts at
    // its boundary, so a short pulse mid-execute still halts afterwards.
    assign w_stop_pending = bus.stop | r_stop_req;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RST;
            r_stop_req <= 1'b0;
        end else begin
            r_stop_req <= w_stop_pending & w_running & ~w_boundary;
            case (r_state)
                ST_RST:  r_state <= ST_T0;
                ST_T0:   r_state <= ST_T1;
                ST_T1:   r_state <= ST_T2;
                ST_T2, ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                    if ((r_state == ST_T2) && (w_cls == CLS_HALT)) begin
                        r_state <= ST_HALT;
                    end else if (w_boundary) begin
                        r_state <= w_stop_pending ? ST_HALT : ST_T0;
                    end else begin
                        r_state <= state_t'(r_state + 4'd1);
                    end
                end
                ST_HALT: r_state <= ST_HALT;
                default: r_state <= ST_RST;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Moore output decode. RST/HALT (and any stray encoding) drive all 0,
    // so an asynchronous reset clears every strobe immediately.
    // ------------------------------------------------------------------
    always_comb begin
        w_ctrl   = '0;
        w_alu_op = '0;
        case (r_state)
            ST_T0: begin
                // alu_op stays 0: the PC-increment path owns this Zin
                w_ctrl.pc_out = 1'b1;
                w_ctrl.mar_in = 1'b1;
                w_ctrl.inc_pc = 1'b1;
                w_ctrl.z_in   = 1'b1;
            end
            ST_T1: begin
                w_ctrl.zlow_out = 1'b1;
                w_ctrl.pc_in    = 1'b1;
                w_ctrl.read     = 1'b1;
                w_ctrl.mdr_in   = 1'b1;
            end
            ST_T2: begin
                w_ctrl.mdr_out = 1'b1;
                w_ctrl.ir_in   = 1'b1;
            end
            ST_T3: begin
                case (w_cls)
                    CLS_ALU3, CLS_IMM: begin
                        w_ctrl.grb   = 1'b1;
                        w_ctrl.r_out = 1'b1;
                        w_ctrl.y_in  = 1'b1;
                    end
                    CLS_UNARY: begin
                        w_ctrl.grb   = 1'b1;
                        w_ctrl.r_out = 1'b1;
                        w_ctrl.z_in  = 1'b1;
                        w_alu_op     = w_op;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.gra   = 1'b1;
                        w_ctrl.r_out = 1'b1;
                        w_ctrl.y_in  = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        w_ctrl.grb    = 1'b1;
                        w_ctrl.ba_out = 1'b1;
                        w_ctrl.y_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T4: begin
                case (w_cls)
                    CLS_ALU3: begin
                        w_ctrl.grc   = 1'b1;
                        w_ctrl.r_out = 1'b1;
                        w_ctrl.z_in  = 1'b1;
                        w_alu_op     = w_op;
                    end
                    CLS_IMM: begin
                        w_ctrl.c_out = 1'b1;
                        w_ctrl.z_in  = 1'b1;
                        w_alu_op     = w_op;
                    end
                    CLS_UNARY: begin
                        w_ctrl.zlow_out = 1'b1;
                        w_ctrl.gra      = 1'b1;
                        w_ctrl.r_in     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.grb   = 1'b1;
                        w_ctrl.r_out = 1'b1;
                        w_ctrl.z_in  = 1'b1;
                        w_alu_op     = w_op;
                    end
                    CLS_LD, CLS_ST: begin
                        // effective address = base + C
                        w_ctrl.c_out = 1'b1;
                        w_ctrl.z_in  = 1'b1;
                        w_alu_op     = OP_ADD;
                    end
                    default: ;
                endcase
            end
            ST_T5: begin
                case (w_cls)
                    CLS_ALU3, CLS_IMM: begin
                        w_ctrl.zlow_out = 1'b1;
                        w_ctrl.gra      = 1'b1;
                        w_ctrl.r_in     = 1'b1;
                    end
                    CLS_MULDIV: begin
                        w_ctrl.zlow_out = 1'b1;
                        w_ctrl.lo_in    = 1'b1;
                    end
                    CLS_LD, CLS_ST: begin
                        w_ctrl.zlow_out = 1'b1;
                        w_ctrl.mar_in   = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T6: begin
                case (w_cls)
                    CLS_MULDIV: begin
                        w_ctrl.zhigh_out = 1'b1;
                        w_ctrl.hi_in     = 1'b1;
                    end
                    CLS_LD: begin
                        w_ctrl.read   = 1'b1;
                        w_ctrl.mdr_in = 1'b1;
                    end
                    CLS_ST: begin
                        w_ctrl.gra    = 1'b1;
                        w_ctrl.r_out  = 1'b1;
                        w_ctrl.mdr_in = 1'b1;
                    end
                    default: ;
                endcase
            end
            ST_T7: begin
                case (w_cls)
                    CLS_LD: begin
                        w_ctrl.mdr_out = 1'b1;
                        w_ctrl.gra     = 1'b1;
                        w_ctrl.r_in    = 1'b1;
                    end
                    CLS_ST: begin
                        w_ctrl.write = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign bus.pc_out    = w_ctrl.pc_out;
    assign bus.zhigh_out = w_ctrl.zhigh_out;
    assign bus.zlow_out  = w_ctrl.zlow_out;
    assign bus.mdr_out   = w_ctrl.mdr_out;
    assign bus.c_out     = w_ctrl.c_out;
    assign bus.ba_out    = w_ctrl.ba_out;
    assign bus.mar_in    = w_ctrl.mar_in;
    assign bus.z_in      = w_ctrl.z_in;
    assign bus.pc_in     = w_ctrl.pc_in;
    assign bus.mdr_in    = w_ctrl.mdr_in;
    assign bus.ir_in     = w_ctrl.ir_in;
    assign bus.y_in      = w_ctrl.y_in;
    assign bus.hi_in     = w_ctrl.hi_in;
    assign bus.lo_in     = w_ctrl.lo_in;
    assign bus.inc_pc    = w_ctrl.inc_pc;
    assign bus.read      = w_ctrl.read;
    assign bus.write     = w_ctrl.write;
    assign bus.gra       = w_ctrl.gra;
    assign bus.grb       = w_ctrl.grb;
    assign bus.grc       = w_ctrl.grc;
    assign bus.r_in      = w_ctrl.r_in;
    assign bus.r_out     = w_ctrl.r_out;
    assign bus.alu_op    = w_alu_op;
    assign bus.run       = w_running;

endmodule
`default_nettype wire
